// File: rtl/regfile_wb_arb.sv
// ---------------------------------------------------------------------------
// regfile_wb_arb
//
// Shares the single write port of the 32x64 integer register file between
// the ALU/EX writeback path and the LSU load path. It also keeps a
// pending-write scoreboard that decode uses to stall on RAW hazards.
//
// Arbitration is round-robin between the two requesters. The winning
// request is registered into a one-cycle output stage (we_o/waddr_o/wdata_o),
// and the regfile commits it on the following edge. A write to x0 still
// completes its handshake, but it never raises we_o.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   flush_i               synchronous flush: blocks grants, clears pending,
//                         kills the output-stage write on that edge
//   alu_valid_i/ready_o   ALU writeback handshake (+ waddr/wdata)
//   lsu_valid_i/ready_o   LSU writeback handshake (+ waddr/wdata)
//   iss_valid_i, iss_rd_i destination of an instruction issued this cycle
//   we_o, waddr_o, wdata_o  registered regfile write port
//   pending_o             bit i set = register i has an outstanding write
// ---------------------------------------------------------------------------
module regfile_wb_arb #(
    parameter int XLEN = 64,
    parameter int NREG = 32,
    parameter int AW   = 5
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush_i,

    input  logic            alu_valid_i,
    output logic            alu_ready_o,
    input  logic [AW-1:0]   alu_waddr_i,
    input  logic [XLEN-1:0] alu_wdata_i,

    input  logic            lsu_valid_i,
    output logic            lsu_ready_o,
    input  logic [AW-1:0]   lsu_waddr_i,
    input  logic [XLEN-1:0] lsu_wdata_i,

    input  logic            iss_valid_i,
    input  logic [AW-1:0]   iss_rd_i,

    output logic            we_o,
    output logic [AW-1:0]   waddr_o,
    output logic [XLEN-1:0] wdata_o,
    output logic [NREG-1:0] pending_o
);

    typedef enum logic {
        GRANT_ALU = 1'b0,
        GRANT_LSU = 1'b1
    } grant_e;

    grant_e            last_grant_q, last_grant_d;
    logic              we_q, we_d;
    logic [AW-1:0]     waddr_q, waddr_d;
    logic [XLEN-1:0]   wdata_q, wdata_d;
    logic [NREG-1:0]   pending_q, pending_d;

    // -----------------------------------------------------------------------
    // Arbitration. The ALU wins if it is the only requester, or if both
    // request and the LSU won last time. Otherwise the LSU gets the port
    // whenever it asks. Ready stays low while in reset so that nothing is
    // consumed before the state is valid.
    // -----------------------------------------------------------------------
    always_comb begin
        // NOTE: every combinational output gets a default first, so no path
        // leaves it unassigned and no latch is inferred.
        alu_ready_o = 1'b0;
        lsu_ready_o = 1'b0;
        if (rst_n && !flush_i) begin
            if (alu_valid_i && (!lsu_valid_i || last_grant_q == GRANT_LSU)) begin
                alu_ready_o = 1'b1;
            end else if (lsu_valid_i) begin
                lsu_ready_o = 1'b1;
            end
        end
    end

    // -----------------------------------------------------------------------
    // Output stage and round-robin pointer. A ready implies the matching
    // valid, so a ready here means a transfer happens this edge. Flush never
    // produces a ready, so it falls through to we_d = 0.
    // -----------------------------------------------------------------------
    always_comb begin
        last_grant_d = last_grant_q;
        we_d         = 1'b0;
        waddr_d      = waddr_q;
        wdata_d      = wdata_q;
        if (alu_ready_o) begin
            last_grant_d = GRANT_ALU;
            we_d         = (alu_waddr_i != '0);
            waddr_d      = alu_waddr_i;
            wdata_d      = alu_wdata_i;
        end else if (lsu_ready_o) begin
            last_grant_d = GRANT_LSU;
            we_d         = (lsu_waddr_i != '0);
            waddr_d      = lsu_waddr_i;
            wdata_d      = lsu_wdata_i;
        end
    end

    // -----------------------------------------------------------------------
    // Scoreboard. A new issue to a register takes priority over the retiring
    // write to that register: the new producer supersedes the old one, so
    // the bit must stay set. x0 never becomes pending.
    // -----------------------------------------------------------------------
    always_comb begin
        pending_d = pending_q;
        for (int i = 1; i < NREG; i++) begin
            if (flush_i) begin
                pending_d[i] = 1'b0;
            end else if (iss_valid_i && iss_rd_i == AW'(i)) begin
                pending_d[i] = 1'b1;
            end else if (we_q && waddr_q == AW'(i)) begin
                pending_d[i] = 1'b0;
            end
        end
        pending_d[0] = 1'b0;
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // flop samples its pre-edge inputs no matter how the blocks are ordered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: the scoreboard is ordinary control state. Decode trusts
            // it straight out of reset, so it is reset like every other flop
            // here. It is not left to power-up contents the way a RAM would be.
            last_grant_q <= GRANT_LSU;
            we_q         <= 1'b0;
            waddr_q      <= '0;
            wdata_q      <= '0;
            pending_q    <= '0;
        end else begin
            last_grant_q <= last_grant_d;
            we_q         <= we_d;
            waddr_q      <= waddr_d;
            wdata_q      <= wdata_d;
            pending_q    <= pending_d;
        end
    end

    assign we_o      = we_q;
    assign waddr_o   = waddr_q;
    assign wdata_o   = wdata_q;
    assign pending_o = pending_q;

endmodule

// File: tb/tb_regfile_wb_arb.sv
// ---------------------------------------------------------------------------
// tb_regfile_wb_arb
//
// Directed steps followed by a randomized phase. All steps are checked
// against a behavioural model of the write-port arbiter and the scoreboard.
// The model is advanced once per rising edge. Inputs change 1 time unit
// after the rising edge, and outputs are sampled on the falling edge.
// ---------------------------------------------------------------------------
module tb_regfile_wb_arb;

    localparam int XLEN = 64;
    localparam int NREG = 32;
    localparam int AW   = 5;
    localparam int ALU  = 0;
    localparam int LSU  = 1;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            flush_i;
    logic            alu_valid_i, alu_ready_o;
    logic [AW-1:0]   alu_waddr_i;
    logic [XLEN-1:0] alu_wdata_i;
    logic            lsu_valid_i, lsu_ready_o;
    logic [AW-1:0]   lsu_waddr_i;
    logic [XLEN-1:0] lsu_wdata_i;
    logic            iss_valid_i;
    logic [AW-1:0]   iss_rd_i;
    logic            we_o;
    logic [AW-1:0]   waddr_o;
    logic [XLEN-1:0] wdata_o;
    logic [NREG-1:0] pending_o;

    regfile_wb_arb #(.XLEN(XLEN), .NREG(NREG), .AW(AW)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .flush_i     (flush_i),
        .alu_valid_i (alu_valid_i),
        .alu_ready_o (alu_ready_o),
        .alu_waddr_i (alu_waddr_i),
        .alu_wdata_i (alu_wdata_i),
        .lsu_valid_i (lsu_valid_i),
        .lsu_ready_o (lsu_ready_o),
        .lsu_waddr_i (lsu_waddr_i),
        .lsu_wdata_i (lsu_wdata_i),
        .iss_valid_i (iss_valid_i),
        .iss_rd_i    (iss_rd_i),
        .we_o        (we_o),
        .waddr_o     (waddr_o),
        .wdata_o     (wdata_o),
        .pending_o   (pending_o)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Behavioural model state
    bit              m_we;
    bit [AW-1:0]     m_waddr;
    bit [XLEN-1:0]   m_wdata;
    bit              m_pend[NREG];
    int              m_last;

    // Values observed at the most recent falling edge
    logic            obs_alu_rdy, obs_lsu_rdy, obs_we;
    logic [AW-1:0]   obs_waddr;
    logic [XLEN-1:0] obs_wdata;
    logic [NREG-1:0] obs_pend;

    // Previous-cycle requester state, used by the handshake-hold assertion
    logic            p_av = 1'b0, p_ar = 1'b0, p_lv = 1'b0, p_lr = 1'b0;
    logic [AW-1:0]   p_aa, p_la;
    logic [XLEN-1:0] p_ad, p_ld;

    int alu_wait = 0;
    int lsu_wait = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_we    = 1'b0;
        m_waddr = '0;
        m_wdata = '0;
        m_last  = LSU;
        for (int i = 0; i < NREG; i++) m_pend[i] = 1'b0;
    endtask

    function automatic logic [NREG-1:0] model_pend();
        logic [NREG-1:0] v;
        for (int i = 0; i < NREG; i++) v[i] = m_pend[i];
        return v;
    endfunction

    // Grant rules. Nothing is granted in reset or during a flush. A lone
    // requester always wins. On a tie, the requester that did not win last
    // time gets the port.
    task automatic model_ready(output bit ra, output bit rl);
        ra = 1'b0;
        rl = 1'b0;
        if (rst_n && !flush_i) begin
            if (alu_valid_i && lsu_valid_i) begin
                ra = (m_last == LSU);
                rl = (m_last == ALU);
            end else begin
                ra = alu_valid_i;
                rl = lsu_valid_i;
            end
        end
    endtask

    // One clock cycle. The inputs are assumed to be driven already.
    task automatic cycle();
        bit ra, rl;
        bit old_we;
        bit [AW-1:0] old_waddr;
        @(negedge clk);
        model_ready(ra, rl);
        check("alu_ready", alu_ready_o, ra);
        check("lsu_ready", lsu_ready_o, rl);
        check("we",        we_o,        m_we);
        check("waddr",     waddr_o,     m_waddr);
        check("wdata",     wdata_o,     m_wdata);
        check("pending",   pending_o,   model_pend());
        obs_alu_rdy = alu_ready_o;
        obs_lsu_rdy = lsu_ready_o;
        obs_we      = we_o;
        obs_waddr   = waddr_o;
        obs_wdata   = wdata_o;
        obs_pend    = pending_o;

        // A valid request must stay unchanged until it is granted.
        if (rst_n && p_av && !p_ar)
            assert (alu_valid_i && alu_waddr_i == p_aa && alu_wdata_i == p_ad)
                else $error("ALU request dropped or changed before ready");
        if (rst_n && p_lv && !p_lr)
            assert (lsu_valid_i && lsu_waddr_i == p_la && lsu_wdata_i == p_ld)
                else $error("LSU request dropped or changed before ready");
        p_av = alu_valid_i && rst_n; p_ar = alu_ready_o; p_aa = alu_waddr_i; p_ad = alu_wdata_i;
        p_lv = lsu_valid_i && rst_n; p_lr = lsu_ready_o; p_la = lsu_waddr_i; p_ld = lsu_wdata_i;

        // A valid requester may wait at most one cycle outside of a flush.
        if (rst_n && !flush_i) begin
            alu_wait = (alu_valid_i && !alu_ready_o) ? alu_wait + 1 : 0;
            lsu_wait = (lsu_valid_i && !lsu_ready_o) ? lsu_wait + 1 : 0;
            check("alu_fair", alu_wait < 2, 1'b1);
            check("lsu_fair", lsu_wait < 2, 1'b1);
        end

        @(posedge clk);
        if (!rst_n) begin
            model_reset();
        end else begin
            old_we    = m_we;
            old_waddr = m_waddr;
            for (int i = 1; i < NREG; i++) begin
                if (flush_i)                                m_pend[i] = 1'b0;
                else if (iss_valid_i && int'(iss_rd_i) == i) m_pend[i] = 1'b1;
                else if (old_we && int'(old_waddr) == i)     m_pend[i] = 1'b0;
            end
            m_we = 1'b0;
            if (ra) begin
                m_we = (alu_waddr_i != 0); m_waddr = alu_waddr_i; m_wdata = alu_wdata_i; m_last = ALU;
            end else if (rl) begin
                m_we = (lsu_waddr_i != 0); m_waddr = lsu_waddr_i; m_wdata = lsu_wdata_i; m_last = LSU;
            end
        end
        #1;
    endtask

    initial begin : stimulus
        int alu_q[$];
        int lsu_q[$];
        int exp_addr[4];
        bit a_busy, l_busy;
        int guard;

        model_reset();
        rst_n = 1'b0; flush_i = 1'b0;
        alu_valid_i = 1'b0; alu_waddr_i = '0; alu_wdata_i = '0;
        lsu_valid_i = 1'b0; lsu_waddr_i = '0; lsu_wdata_i = '0;
        iss_valid_i = 1'b0; iss_rd_i = '0;
        #1;

        // 1. Reset with the ALU already requesting. The first tie-free grant
        //    goes to the ALU, and the write appears one cycle later.
        alu_valid_i = 1'b1; alu_waddr_i = 5; alu_wdata_i = 64'hDEAD;
        cycle();
        check("t1_rst_ready", obs_alu_rdy, 1'b0);
        check("t1_rst_we",    obs_we,      1'b0);
        check("t1_rst_pend",  obs_pend,    '0);
        rst_n = 1'b1;
        cycle();
        check("t1_alu_ready", obs_alu_rdy, 1'b1);
        alu_valid_i = 1'b0;
        cycle();
        check("t1_we",    obs_we,    1'b1);
        check("t1_waddr", obs_waddr, 5);
        check("t1_wdata", obs_wdata, 64'hDEAD);

        // 3. An LSU write to x0 completes the handshake without a regfile
        //    write. Issuing x0 leaves the scoreboard untouched.
        lsu_valid_i = 1'b1; lsu_waddr_i = 0; lsu_wdata_i = 64'h123;
        iss_valid_i = 1'b1; iss_rd_i = 0;
        cycle();
        check("t3_lsu_ready", obs_lsu_rdy, 1'b1);
        lsu_valid_i = 1'b0; iss_valid_i = 1'b0;
        cycle();
        check("t3_we",   obs_we,   1'b0);
        check("t3_pend", obs_pend, '0);

        // 2. Round-robin. Both requesters are valid for four cycles, and the
        //    LSU won last, so the grants must alternate starting with the ALU.
        alu_q = '{1, 2};
        lsu_q = '{3, 4};
        exp_addr = '{1, 3, 2, 4};
        for (int k = 0; k <= 4; k++) begin
            alu_valid_i = (alu_q.size() > 0);
            alu_waddr_i = (alu_q.size() > 0) ? AW'(alu_q[0]) : '0;
            alu_wdata_i = 64'hA0 + 64'(alu_waddr_i);
            lsu_valid_i = (lsu_q.size() > 0);
            lsu_waddr_i = (lsu_q.size() > 0) ? AW'(lsu_q[0]) : '0;
            lsu_wdata_i = 64'hB0 + 64'(lsu_waddr_i);
            cycle();
            if (k > 0) begin
                check("t2_we",    obs_we,    1'b1);
                check("t2_waddr", obs_waddr, exp_addr[k-1]);
            end
            if (k < 4) check("t2_alu_turn", obs_alu_rdy, (k % 2) == 0);
            if (obs_alu_rdy && alu_q.size() > 0) void'(alu_q.pop_front());
            if (obs_lsu_rdy && lsu_q.size() > 0) void'(lsu_q.pop_front());
        end
        alu_valid_i = 1'b0; lsu_valid_i = 1'b0;

        // 4. Scoreboard set, clear one edge after we_o, and set winning over
        //    clear on the same register.
        iss_valid_i = 1'b1; iss_rd_i = 7;
        cycle();
        iss_valid_i = 1'b0;
        cycle();
        check("t4_set", obs_pend[7], 1'b1);
        alu_valid_i = 1'b1; alu_waddr_i = 7; alu_wdata_i = 64'h77;
        cycle();
        alu_valid_i = 1'b0;
        cycle();
        check("t4_we_x7", obs_we,      1'b1);
        check("t4_hold",  obs_pend[7], 1'b1);
        cycle();
        check("t4_clr",   obs_pend[7], 1'b0);
        alu_valid_i = 1'b1; alu_waddr_i = 7; alu_wdata_i = 64'h78;
        cycle();
        alu_valid_i = 1'b0; iss_valid_i = 1'b1; iss_rd_i = 7;
        cycle();
        check("t4_we_overlap", obs_we, 1'b1);
        iss_valid_i = 1'b0;
        cycle();
        check("t4_set_wins", obs_pend[7], 1'b1);

        // 5. Flush with 0xF0 pending and both requesters valid.
        for (int r = 4; r < 7; r++) begin
            iss_valid_i = 1'b1; iss_rd_i = AW'(r);
            cycle();
        end
        iss_valid_i = 1'b0;
        cycle();
        check("t5_pend_f0", obs_pend, 32'h0000_00F0);
        alu_valid_i = 1'b1; alu_waddr_i = 10; alu_wdata_i = 64'hA10;
        lsu_valid_i = 1'b1; lsu_waddr_i = 11; lsu_wdata_i = 64'hB11;
        flush_i = 1'b1;
        cycle();
        check("t5_alu_blocked", obs_alu_rdy, 1'b0);
        check("t5_lsu_blocked", obs_lsu_rdy, 1'b0);
        flush_i = 1'b0;
        cycle();
        check("t5_pend_clr", obs_pend, '0);
        check("t5_we",       obs_we,   1'b0);
        check("t5_resume",   obs_alu_rdy | obs_lsu_rdy, 1'b1);
        if (obs_alu_rdy) alu_valid_i = 1'b0;
        else             lsu_valid_i = 1'b0;
        cycle();
        alu_valid_i = 1'b0; lsu_valid_i = 1'b0;
        cycle();

        // Randomized traffic against the model.
        a_busy = 1'b0; l_busy = 1'b0;
        for (int n = 0; n < 400; n++) begin
            if (!a_busy && $urandom_range(2) == 0) begin
                a_busy = 1'b1;
                alu_waddr_i = AW'($urandom_range(NREG - 1));
                alu_wdata_i = {$urandom, $urandom};
            end
            if (!l_busy && $urandom_range(2) == 0) begin
                l_busy = 1'b1;
                lsu_waddr_i = AW'($urandom_range(NREG - 1));
                lsu_wdata_i = {$urandom, $urandom};
            end
            alu_valid_i = a_busy;
            lsu_valid_i = l_busy;
            flush_i     = ($urandom_range(19) == 0);
            iss_valid_i = $urandom_range(1);
            iss_rd_i    = AW'($urandom_range(NREG - 1));
            cycle();
            if (obs_alu_rdy) a_busy = 1'b0;
            if (obs_lsu_rdy) l_busy = 1'b0;
        end
        flush_i = 1'b0; iss_valid_i = 1'b0;
        guard = 0;
        while ((a_busy || l_busy) && guard < 10) begin
            alu_valid_i = a_busy;
            lsu_valid_i = l_busy;
            cycle();
            if (obs_alu_rdy) a_busy = 1'b0;
            if (obs_lsu_rdy) l_busy = 1'b0;
            guard++;
        end
        if (a_busy || l_busy) check("drain_timeout", 1'b0, 1'b1);
        alu_valid_i = 1'b0; lsu_valid_i = 1'b0;
        cycle();

        // 6. Asynchronous reset between edges while a write is in flight.
        alu_valid_i = 1'b1; alu_waddr_i = 9; alu_wdata_i = 64'h99;
        iss_valid_i = 1'b1; iss_rd_i = 9;
        cycle();
        alu_valid_i = 1'b0; iss_valid_i = 1'b0;
        #2;
        check("t6_pre_we",   we_o,      1'b1);
        check("t6_pre_pend", pending_o[9], 1'b1);
        rst_n = 1'b0;
        #1;
        check("t6_we",    we_o,      1'b0);
        check("t6_pend",  pending_o, '0);
        check("t6_waddr", waddr_o,   '0);
        check("t6_wdata", wdata_o,   '0);
        model_reset();
        cycle();
        rst_n = 1'b1;
        cycle();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/regfile_wb_arb.md
Name: regfile_wb_arb

Overview:
- Write-port arbiter and pending-write scoreboard for the 32x64 integer register file, which has a single write port.
- Shares that write port between two writeback requesters, the ALU/EX path and the LSU load path, using round-robin arbitration and a registered output stage.
- Tracks which architectural registers have an issued-but-unretired write, so that decode can stall on RAW hazards.
- The regfile's own write-to-read bypass covers the retire cycle.

Parameters:
XLEN, 64, data width of register writes
NREG, 32, number of architectural registers
AW, 5, register address width (log2 NREG)

Ports:
clk  input  1  clock; all state updates on rising edge
rst_n  input  1  asynchronous active-low reset
flush_i  input  1  synchronous pipeline flush
alu_valid_i  input  1  ALU write request
alu_ready_o  output  1  ALU request granted this cycle
alu_waddr_i  input  AW  ALU destination register
alu_wdata_i  input  XLEN  ALU write data
lsu_valid_i  input  1  LSU write request
lsu_ready_o  output  1  LSU request granted this cycle
lsu_waddr_i  input  AW  LSU destination register
lsu_wdata_i  input  XLEN  LSU write data
iss_valid_i  input  1  instruction with a destination issued this cycle
iss_rd_i  input  AW  destination of the issued instruction
we_o  output  1  regfile write enable
waddr_o  output  AW  regfile write address
wdata_o  output  XLEN  regfile write data
pending_o  output  NREG  bit i = register i has an outstanding write

Behaviour:
- Reset (rst_n low, asynchronous):
  - we_o=0, waddr_o=0, wdata_o=0, pending_o=0.
  - last_grant=LSU, so the ALU wins the first tie.
  - ready outputs are 0 while rst_n is low.
- Handshake:
  - A transfer occurs when valid and ready are both high on a rising edge.
  - Once a requester raises valid, it holds valid, waddr and wdata stable until ready. The bench asserts this.
  - Each ready is combinational from the valids, flush_i and last_grant. There is no path from ready to valid.
- Arbitration (combinational):
  - flush_i=1: both ready=0.
  - Only one valid: that requester gets ready=1.
  - Both valid: the requester not equal to last_grant gets ready=1.
  - last_grant updates to the winner only on a transfer.
  - At most one ready is high per cycle.
  - Fairness bound: a valid requester is granted within 2 cycles.
- Output stage, latency 1:
  - On the edge where a transfer occurs, waddr_o and wdata_o load the winner's fields. we_o loads 1 if the winner's waddr != 0, else 0.
  - With no transfer, we_o<=0 and waddr_o/wdata_o hold their values.
  - The regfile commits on the edge after we_o is high.
  - A write to x0 completes the handshake but never asserts we_o.
- Scoreboard, per bit i with 1<=i<NREG, evaluated at each edge:
  - set = iss_valid_i && iss_rd_i==i
  - clr = we_o && waddr_o==i
  - if flush_i: pending[i]<=0; else if set: pending[i]<=1; else if clr: pending[i]<=0.
  - Set beats clear on the same index in the same cycle, because a new producer supersedes the retiring one.
  - pending[0] is constant 0.
  - iss_rd_i==0 has no effect.
- Flush:
  - Clears pending and forces we_o<=0 on that edge.
  - Blocks grants that cycle. Requester state is not consumed; requesters drop their own valids.
- Reset mid-operation: all state returns immediately to reset values, and any in-flight output-stage write is lost.
- Widths: no arithmetic. Addresses are compared at the full AW width.

Test Plan:
1. Reset: rst_n=0 with alu_valid_i=1 -> we_o=0, pending_o=0, alu_ready_o=0. Release reset with alu_valid_i=1, alu_waddr_i=5, alu_wdata_i=0xDEAD -> alu_ready_o=1, and next cycle we_o=1, waddr_o=5, wdata_o=0xDEAD.
2. Round-robin: both valid for 4 cycles, ALU (waddr 1,2) and LSU (waddr 3,4) each advancing on their own grants -> grant order ALU, LSU, ALU, LSU; we_o pulses with waddr_o=1,3,2,4 on consecutive cycles.
3. x0 write: lsu_valid_i=1, lsu_waddr_i=0 -> lsu_ready_o=1, and next cycle we_o=0. Also iss_rd_i=0 leaves pending_o=0.
4. Scoreboard:
   - iss x7 -> pending_o[7]=1.
   - ALU writes x7 -> pending_o[7] stays 1 during the we_o cycle and clears one edge later.
   - iss x7 in the same cycle as we_o for x7 -> pending_o[7] stays 1.
5. Flush: pending_o=0x0000_00F0 with both requesters valid, then flush_i=1 for 1 cycle -> both ready=0, next cycle pending_o=0 and we_o=0; arbitration resumes the following cycle.
6. Async reset mid-stream: drop rst_n between clock edges while we_o=1 -> we_o and pending_o go to 0 without waiting for a clock edge.
